// File: rtl/gray_counter.sv
// Registered Gray-code counter: up/down count, binary or Gray parallel load, wrap or saturate, terminal-count pulse.
// Latency: one clock from a load/en edge to the new bin_o, gray_o and tc_o, all of which come straight from flops.
// Backpressure: none; en is a plain enable and the counter never stalls whoever drives it.
module gray_counter #(
  parameter int               WIDTH    = 4,
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             tc_o
);

  // Gray image of the reset value, so gray_o is consistent with bin_o straight out of reset.
  localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;

  logic [WIDTH-1:0] w_load_bin_from_gray;
  logic [WIDTH-1:0] w_step;
  logic             w_at_end;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_tc_nxt;

  // Gray-to-binary for the load path: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    w_load_bin_from_gray = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_load_bin_from_gray[i] = ^(load_val >> i);
    end
  end

  // Modulo step in the sampled direction, and whether that step crosses an end of the range.
  assign w_step   = up ? (r_bin + 1'b1) : (r_bin - 1'b1);
  assign w_at_end = up ? (r_bin == '1) : (r_bin == '0);

  // Next binary count and terminal-count flag; load beats en, and hold clears tc.
  always_comb begin
    w_bin_nxt = r_bin;
    w_tc_nxt  = 1'b0;
    if (load) begin
      w_bin_nxt = load_is_gray ? w_load_bin_from_gray : load_val;
    end else if (en) begin
      w_tc_nxt = w_at_end;
      // In saturate mode a blocked step holds the count but still flags tc.
      if (!(SATURATE && w_at_end)) begin
        w_bin_nxt = w_step;
      end
    end
  end

  // Gray is encoded from the next binary value so both registers load on the same edge.
  assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

  // State registers with synchronous reset taking priority over load and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= RST_VAL;
      r_gray <= RST_GRAY;
      r_tc   <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_tc   <= w_tc_nxt;
    end
  end

  assign bin_o  = r_bin;
  assign gray_o = r_gray;
  assign tc_o   = r_tc;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: three instances (4-bit wrap, 4-bit saturate, 8-bit wrap).
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Every scenario task does its own inline comparisons against hand-computed values.
module tb_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=4, wrap
  logic       a_rst = 1'b0, a_en = 1'b0, a_up = 1'b0, a_load = 1'b0, a_lig = 1'b0;
  logic [3:0] a_val = '0;
  logic [3:0] a_bin, a_gray;
  logic       a_tc;

  // Instance B: WIDTH=4, saturate
  logic       b_rst = 1'b0, b_en = 1'b0, b_up = 1'b0, b_load = 1'b0, b_lig = 1'b0;
  logic [3:0] b_val = '0;
  logic [3:0] b_bin, b_gray;
  logic       b_tc;

  // Instance C: WIDTH=8, wrap
  logic       c_rst = 1'b0, c_en = 1'b0, c_up = 1'b0, c_load = 1'b0, c_lig = 1'b0;
  logic [7:0] c_val = '0;
  logic [7:0] c_bin, c_gray;
  logic       c_tc;

  gray_counter #(.WIDTH(4), .SATURATE(1'b0), .RST_VAL(4'd0)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load), .load_is_gray(a_lig),
    .load_val(a_val), .bin_o(a_bin), .gray_o(a_gray), .tc_o(a_tc));

  gray_counter #(.WIDTH(4), .SATURATE(1'b1), .RST_VAL(4'd0)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load), .load_is_gray(b_lig),
    .load_val(b_val), .bin_o(b_bin), .gray_o(b_gray), .tc_o(b_tc));

  gray_counter #(.WIDTH(8), .SATURATE(1'b0), .RST_VAL(8'd0)) u_c (
    .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .load(c_load), .load_is_gray(c_lig),
    .load_val(c_val), .bin_o(c_bin), .gray_o(c_gray), .tc_o(c_tc));

  // One clock on instance A with the given controls, then settle past the edge.
  task automatic a_cycle(input logic rst, input logic en, input logic up,
                         input logic load, input logic lig, input logic [3:0] val);
    @(negedge clk);
    a_rst = rst; a_en = en; a_up = up; a_load = load; a_lig = lig; a_val = val;
    @(posedge clk);
    #1;
  endtask

  task automatic b_cycle(input logic rst, input logic en, input logic up,
                         input logic load, input logic lig, input logic [3:0] val);
    @(negedge clk);
    b_rst = rst; b_en = en; b_up = up; b_load = load; b_lig = lig; b_val = val;
    @(posedge clk);
    #1;
  endtask

  task automatic c_cycle(input logic rst, input logic en, input logic up,
                         input logic load, input logic lig, input logic [7:0] val);
    @(negedge clk);
    c_rst = rst; c_en = en; c_up = up; c_load = load; c_lig = lig; c_val = val;
    @(posedge clk);
    #1;
  endtask

  // Reset must win over a simultaneous load and enable.
  task automatic test_reset;
    a_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010);
    checks++; if (a_bin !== 4'b0000) begin errors++; $display("FAIL reset_bin: got %b want 0000", a_bin); end
    checks++; if (a_gray !== 4'b0000) begin errors++; $display("FAIL reset_gray: got %b want 0000", a_gray); end
    checks++; if (a_tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b want 0", a_tc); end
  endtask

  // Sixteen up-steps from 0: full Gray sequence, single-bit steps, tc only on the wrap.
  task automatic test_wrap;
    logic [3:0] exp_gray [0:16];
    logic [3:0] prev;
    exp_gray = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                 4'b0000};
    a_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    checks++; if (a_gray !== exp_gray[0]) begin errors++; $display("FAIL wrap_start: got %b want %b", a_gray, exp_gray[0]); end
    prev = a_gray;
    for (int k = 1; k <= 16; k++) begin
      a_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      checks++; if (a_gray !== exp_gray[k]) begin errors++; $display("FAIL wrap_gray step %0d: got %b want %b", k, a_gray, exp_gray[k]); end
      checks++; if (a_bin !== 4'(k)) begin errors++; $display("FAIL wrap_bin step %0d: got %b want %b", k, a_bin, 4'(k)); end
      checks++; if ($countones(a_gray ^ prev) != 1) begin errors++; $display("FAIL wrap_onebit step %0d: %b -> %b", k, prev, a_gray); end
      checks++; if (a_tc !== (k == 16)) begin errors++; $display("FAIL wrap_tc step %0d: got %b want %b", k, a_tc, (k == 16)); end
      prev = a_gray;
    end
  endtask

  // Gray load straight after the wrap pulse: converts and clears tc.
  task automatic test_gray_load;
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1110);
    checks++; if (a_bin !== 4'b1011) begin errors++; $display("FAIL gload_bin: got %b want 1011", a_bin); end
    checks++; if (a_gray !== 4'b1110) begin errors++; $display("FAIL gload_gray: got %b want 1110", a_gray); end
    checks++; if (a_tc !== 1'b0) begin errors++; $display("FAIL gload_tc: got %b want 0", a_tc); end
  endtask

  // Binary load of 1, two down-steps through zero, then hold.
  task automatic test_bin_load_down;
    a_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001);
    checks++; if (a_bin !== 4'b0001 || a_gray !== 4'b0001) begin errors++; $display("FAIL bload: got bin %b gray %b want 0001 0001", a_bin, a_gray); end
    a_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    checks++; if (a_bin !== 4'b0000 || a_gray !== 4'b0000 || a_tc !== 1'b0) begin errors++; $display("FAIL down1: got bin %b gray %b tc %b want 0000 0000 0", a_bin, a_gray, a_tc); end
    a_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    checks++; if (a_bin !== 4'b1111 || a_gray !== 4'b1000 || a_tc !== 1'b1) begin errors++; $display("FAIL down_wrap: got bin %b gray %b tc %b want 1111 1000 1", a_bin, a_gray, a_tc); end
    a_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    checks++; if (a_bin !== 4'b1111 || a_gray !== 4'b1000 || a_tc !== 1'b0) begin errors++; $display("FAIL hold: got bin %b gray %b tc %b want 1111 1000 0", a_bin, a_gray, a_tc); end
    // Direction reversal on consecutive cycles.
    a_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    checks++; if (a_bin !== 4'b0000 || a_tc !== 1'b1) begin errors++; $display("FAIL rev_up: got bin %b tc %b want 0000 1", a_bin, a_tc); end
    a_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    checks++; if (a_bin !== 4'b1111 || a_gray !== 4'b1000 || a_tc !== 1'b1) begin errors++; $display("FAIL rev_down: got bin %b gray %b tc %b want 1111 1000 1", a_bin, a_gray, a_tc); end
  endtask

  // Saturating instance: blocked steps hold and pulse tc every enabled cycle.
  task automatic test_saturate;
    b_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    b_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111);
    checks++; if (b_bin !== 4'b1111 || b_tc !== 1'b0) begin errors++; $display("FAIL sat_load: got bin %b tc %b want 1111 0", b_bin, b_tc); end
    for (int k = 0; k < 3; k++) begin
      b_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      checks++; if (b_bin !== 4'b1111 || b_gray !== 4'b1000 || b_tc !== 1'b1) begin errors++; $display("FAIL sat_up %0d: got bin %b gray %b tc %b want 1111 1000 1", k, b_bin, b_gray, b_tc); end
    end
    b_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    checks++; if (b_bin !== 4'b1110 || b_gray !== 4'b1001 || b_tc !== 1'b0) begin errors++; $display("FAIL sat_back: got bin %b gray %b tc %b want 1110 1001 0", b_bin, b_gray, b_tc); end
    b_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    b_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    checks++; if (b_bin !== 4'b0000 || b_tc !== 1'b1) begin errors++; $display("FAIL sat_down: got bin %b tc %b want 0000 1", b_bin, b_tc); end
  endtask

  // Load beats enable; reset beats both.
  task automatic test_priority;
    a_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int k = 0; k < 5; k++) a_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    checks++; if (a_bin !== 4'b0101 || a_gray !== 4'b0111) begin errors++; $display("FAIL prio_count: got bin %b gray %b want 0101 0111", a_bin, a_gray); end
    a_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0011);
    checks++; if (a_bin !== 4'b0011 || a_gray !== 4'b0010 || a_tc !== 1'b0) begin errors++; $display("FAIL prio_load: got bin %b gray %b tc %b want 0011 0010 0", a_bin, a_gray, a_tc); end
    a_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0011);
    checks++; if (a_bin !== 4'b0000 || a_gray !== 4'b0000 || a_tc !== 1'b0) begin errors++; $display("FAIL prio_rst: got bin %b gray %b tc %b want 0000 0000 0", a_bin, a_gray, a_tc); end
    a_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  // 8-bit sweep: 256 up-steps, Gray relation and single-bit change each step, one tc at 255 -> 0.
  task automatic test_width_sweep;
    logic [7:0] prev;
    logic [7:0] exp_bin;
    int         tc_seen;
    c_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (c_bin !== 8'h00 || c_gray !== 8'h00) begin errors++; $display("FAIL sweep_reset: got bin %h gray %h want 00 00", c_bin, c_gray); end
    prev    = c_gray;
    exp_bin = 8'h00;
    tc_seen = 0;
    for (int k = 1; k <= 256; k++) begin
      c_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      exp_bin = exp_bin + 8'h01;
      checks++; if (c_bin !== exp_bin) begin errors++; $display("FAIL sweep_bin step %0d: got %h want %h", k, c_bin, exp_bin); end
      checks++; if (c_gray !== (exp_bin ^ (exp_bin >> 1))) begin errors++; $display("FAIL sweep_gray step %0d: got %h want %h", k, c_gray, exp_bin ^ (exp_bin >> 1)); end
      checks++; if ($countones(c_gray ^ prev) != 1) begin errors++; $display("FAIL sweep_onebit step %0d: %h -> %h", k, prev, c_gray); end
      checks++; if (c_tc !== (k == 256)) begin errors++; $display("FAIL sweep_tc step %0d: got %b want %b", k, c_tc, (k == 256)); end
      if (c_tc === 1'b1) tc_seen++;
      prev = c_gray;
    end
    checks++; if (tc_seen != 1) begin errors++; $display("FAIL sweep_tc_count: got %0d want 1", tc_seen); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_gray_load();
    test_bin_load_down();
    test_saturate();
    test_priority();
    test_width_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
